// File: rtl/seq_divider_if.sv
// Start/busy/done handshake bundle shared by the sequential multiply/divide units.
// The controller drives operands and start; the arithmetic unit returns status and results.
interface seq_divider_if #(
  parameter int dw = 8
);
  logic          start;
  logic [dw-1:0] dividend;
  logic [dw-1:0] divisor;
  logic          busy;
  logic          done;
  logic [dw-1:0] quotient;
  logic [dw-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned quotient and remainder, one bit per clock.
// A nonzero divisor takes dw iterations in RUN followed by a single DONE cycle.
// A zero divisor skips RUN and reports all-ones quotient, remainder = dividend.
module seq_divider #(
  parameter int dw = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(dw);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [dw-1:0] dvs_r;
  logic [dw-1:0] quo_r;
  logic [dw-1:0] rem_r;
  logic [CW-1:0] count;
  logic          busy_r;
  logic          done_r;
  logic          dbz_r;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // trial-subtract with a guard bit, keep the difference only if it did not borrow.
  function automatic logic [2*dw-1:0] div_step(
    input logic [dw-1:0] rem,
    input logic [dw-1:0] quo,
    input logic [dw-1:0] dvs
  );
    logic [dw:0] t;
    logic [dw:0] d;
    t = {rem, quo[dw-1]};
    d = t - {1'b0, dvs};
    if (!d[dw])
      div_step = {d[dw-1:0], quo[dw-2:0], 1'b1};
    else
      div_step = {t[dw-1:0], quo[dw-2:0], 1'b0};
  endfunction

  // Control FSM with registered handshake outputs and the shared quotient/remainder datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dvs_r  <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            if (bus.divisor != '0) begin
              dvs_r  <= bus.divisor;
              quo_r  <= bus.dividend;
              rem_r  <= '0;
              count  <= CW'(dw - 1);
              dbz_r  <= 1'b0;
              busy_r <= 1'b1;
              state  <= RUN;
            end else begin
              // Divide by zero resolves immediately; no iterations are run.
              quo_r  <= '1;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        RUN: begin
          {rem_r, quo_r} <= div_step(rem_r, quo_r, dvs_r);
          if (count == '0) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            count <= count - CW'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider at dw=8.
module tb_seq_divider;

  localparam int DW = 8;

  logic clk;
  logic reset;
  int   errs;
  int   checks;

  seq_divider_if #(.dw(DW)) bus ();

  seq_divider #(.dw(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge E0.
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen; lat = -1 if the bound expires. Also counts busy-high cycles.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (bus.done !== 1'b1) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (lat >= 40) begin
        lat = -1;
        return;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
      errs++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    issue(8'd100, 8'd7);
    wait_done(lat, bc);
    checks++;
    if (lat !== 8) begin
      errs++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    checks++;
    if (bc !== 8) begin
      errs++;
      $display("FAIL basic_busy_cycles: got %0d want 8", bc);
    end
    checks++;
    if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || bus.div_by_zero !== 1'b0) begin
      errs++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_busy_in_done: got %b want 0", bus.busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
      errs++;
      $display("FAIL basic_hold: got done=%b q=%0d r=%0d want done=0 q=14 r=2",
               bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_vectors();
    logic [DW-1:0] va [5] = '{8'd255, 8'd5, 8'd255, 8'd0,  8'd7};
    logic [DW-1:0] vb [5] = '{8'd1,   8'd9, 8'd255, 8'd5,  8'd200};
    logic [DW-1:0] vq [5] = '{8'd255, 8'd0, 8'd1,   8'd0,  8'd0};
    logic [DW-1:0] vr [5] = '{8'd0,   8'd5, 8'd0,   8'd0,  8'd7};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      issue(va[i], vb[i]);
      wait_done(lat, bc);
      checks++;
      if (lat !== 8 || bus.quotient !== vq[i] || bus.remainder !== vr[i]) begin
        errs++;
        $display("FAIL vector_%0d %0d/%0d: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=8",
                 i, va[i], vb[i], bus.quotient, bus.remainder, lat, vq[i], vr[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    issue(8'd200, 8'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL dbz_timing: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    end
    checks++;
    if (bus.quotient !== 8'd255 || bus.remainder !== 8'd200 || bus.div_by_zero !== 1'b1) begin
      errs++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=200 dbz=1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b1 || bus.quotient !== 8'd255 ||
        bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL dbz_hold: got done=%b dbz=%b q=%0d busy=%b want done=0 dbz=1 q=255 busy=0",
               bus.done, bus.div_by_zero, bus.quotient, bus.busy);
    end
    issue(8'd100, 8'd7);
    checks++;
    if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL dbz_clear: got dbz=%b busy=%b want dbz=0 busy=1", bus.div_by_zero, bus.busy);
    end
    wait_done(lat, bc);
    checks++;
    if (lat !== 8 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
      errs++;
      $display("FAIL dbz_followup: got q=%0d r=%0d lat=%0d want q=14 r=2 lat=8",
               bus.quotient, bus.remainder, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    issue(8'd100, 8'd7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, bc);
    checks++;
    if (lat !== 5 || bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
      errs++;
      $display("FAIL ignore_run: got q=%0d r=%0d lat=%0d want q=14 r=2 lat=5",
               bus.quotient, bus.remainder, lat);
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 8'd14 ||
        bus.remainder !== 8'd2) begin
      errs++;
      $display("FAIL ignore_done: got busy=%b done=%b q=%0d r=%0d want busy=0 done=0 q=14 r=2",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    issue(8'd50, 8'd5);
    wait_done(lat, bc);
    checks++;
    if (lat !== 8 || bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin
      errs++;
      $display("FAIL ignore_third: got q=%0d r=%0d lat=%0d want q=10 r=0 lat=8",
               bus.quotient, bus.remainder, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc;
    int done_seen;
    issue(8'd100, 8'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 19'd0) begin
      errs++;
      $display("FAIL midrun_reset_async: got busy=%b done=%b dbz=%b q=%0d r=%0d want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_seen !== 0) begin
      errs++;
      $display("FAIL midrun_no_done: got %0d active cycles want 0", done_seen);
    end
    issue(8'd9, 8'd2);
    wait_done(lat, bc);
    checks++;
    if (lat !== 8 || bus.quotient !== 8'd4 || bus.remainder !== 8'd1) begin
      errs++;
      $display("FAIL midrun_restart: got q=%0d r=%0d lat=%0d want q=4 r=1 lat=8",
               bus.quotient, bus.remainder, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(8'd37, 8'd6);
    wait_done(lat, bc);
    checks++;
    if (lat !== 8 || bus.quotient !== 8'd6 || bus.remainder !== 8'd1) begin
      errs++;
      $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d want q=6 r=1 lat=8",
               bus.quotient, bus.remainder, lat);
    end
    @(posedge clk);
    #1;
    issue(8'd200, 8'd13);
    wait_done(lat, bc);
    checks++;
    if (lat !== 8 || bus.quotient !== 8'd15 || bus.remainder !== 8'd5) begin
      errs++;
      $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d want q=15 r=5 lat=8",
               bus.quotient, bus.remainder, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    int lat, bc;
    logic [DW-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = DW'($urandom_range(0, 255));
      b = DW'($urandom_range(1, 255));
      issue(a, b);
      wait_done(lat, bc);
      checks++;
      if (lat !== 8 || bus.remainder >= b ||
          (int'(bus.quotient) * int'(b) + int'(bus.remainder)) !== int'(a)) begin
        errs++;
        $display("FAIL sweep_%0d %0d/%0d: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=8",
                 i, a, b, bus.quotient, bus.remainder, lat, a / b, a % b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
